// File: rtl/pin_kinematics.sv
// rtl/pin_kinematics.sv - pin-side physics integrator with coherent snapshot publishing
//
// Purpose: owns authoritative pin state (11.4 / 10.4 fixed-point positions,
// signed 1/16 px velocities, fallen flags), applies collision-detector hits,
// integrates one pin per cycle on each frame tick with friction and lane-exit
// detection, and publishes a coherent snapshot back to the collision detector.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rack_in                 pulse: reload rack layout (aborts a pass)
//   step_in                 pulse: frame tick, start one integration pass
//   coll_done_in            pulse: pins_hit_in / pins_vx_in / pins_vy_in valid
//   pins_hit_in[10]         per-pin hit mask
//   pins_vx_in, pins_vy_in  new signed velocities per pin
//   pins_x_out, pins_y_out  published integer positions
//   pins_vx_out, pins_vy_out published velocities
//   pins_down_out           fallen flags
//   busy_out                integration pass in progress
//   valid_out               pulse: new snapshot published
module pin_kinematics #(
  parameter int SCREEN_WIDTH   = 1024,
  parameter int SCREEN_HEIGHT  = 768,
  parameter int RACK_X         = 512,
  parameter int RACK_Y         = 200,
  parameter int PIN_DX         = 24,
  parameter int PIN_DY         = 40,
  parameter int FRICTION_SHIFT = 3,
  parameter int STOP_THRESH    = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rack_in,
  input  logic              step_in,
  input  logic              coll_done_in,
  input  logic [9:0]        pins_hit_in,
  input  logic [9:0][15:0]  pins_vx_in,
  input  logic [9:0][15:0]  pins_vy_in,
  output logic [9:0][10:0]  pins_x_out,
  output logic [9:0][9:0]   pins_y_out,
  output logic [9:0][15:0]  pins_vx_out,
  output logic [9:0][15:0]  pins_vy_out,
  output logic [9:0]        pins_down_out,
  output logic              busy_out,
  output logic              valid_out
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_PUBLISH} state_t;

  localparam logic signed [15:0] STOP_S = 16'(STOP_THRESH);
  localparam logic [14:0] PARK_X = 15'(SCREEN_WIDTH * 16);
  localparam logic [13:0] PARK_Y = 14'(SCREEN_HEIGHT * 16);
  localparam logic [11:0] LIM_X  = 12'(SCREEN_WIDTH);
  localparam logic [11:0] LIM_Y  = 12'(SCREEN_HEIGHT);

  // Rack geometry: row r, in-row index k from the pin number.
  function automatic int pin_row(input int i);
    if (i == 0) return 0;
    else if (i <= 2) return 1;
    else if (i <= 5) return 2;
    else return 3;
  endfunction

  function automatic int pin_col(input int i);
    if (i == 0) return 0;
    else if (i <= 2) return i - 1;
    else if (i <= 5) return i - 3;
    else return i - 6;
  endfunction

  function automatic logic [10:0] rack_x(input int i);
    return 11'(RACK_X + (2 * pin_col(i) - pin_row(i)) * PIN_DX);
  endfunction

  function automatic logic [9:0] rack_y(input int i);
    return 10'(RACK_Y - pin_row(i) * PIN_DY);
  endfunction

  // Friction from the pre-step velocity; tiny residuals snap to rest.
  function automatic logic [15:0] decay(input logic [15:0] v);
    logic signed [15:0] s;
    logic signed [15:0] f;
    s = signed'(v);
    f = s - (s >>> FRICTION_SHIFT);
    if (f < STOP_S && f > -STOP_S) f = '0;
    return unsigned'(f);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic [9:0]  down_q, down_d;
  logic [9:0]  sh_hit_q, sh_hit_d;
  logic [14:0] x_q [10];
  logic [14:0] x_d [10];
  logic [13:0] y_q [10];
  logic [13:0] y_d [10];
  logic [15:0] vx_q [10];
  logic [15:0] vx_d [10];
  logic [15:0] vy_q [10];
  logic [15:0] vy_d [10];
  logic [15:0] sh_vx_q [10];
  logic [15:0] sh_vx_d [10];
  logic [15:0] sh_vy_q [10];
  logic [15:0] sh_vy_d [10];
  logic [9:0][10:0] pub_x_q, pub_x_d;
  logic [9:0][9:0]  pub_y_q, pub_y_d;
  logic [9:0][15:0] pub_vx_q, pub_vx_d;
  logic [9:0][15:0] pub_vy_q, pub_vy_d;
  logic [9:0]       pub_down_q, pub_down_d;

  logic [16:0] sx, sy;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    pend_d     = pend_q;
    down_d     = down_q;
    sh_hit_d   = sh_hit_q;
    x_d        = x_q;
    y_d        = y_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    sh_vx_d    = sh_vx_q;
    sh_vy_d    = sh_vy_q;
    pub_x_d    = pub_x_q;
    pub_y_d    = pub_y_q;
    pub_vx_d   = pub_vx_q;
    pub_vy_d   = pub_vy_q;
    pub_down_d = pub_down_q;
    // 17-bit signed sums; bit 16 set means the step went below zero.
    sx = {2'b00, x_q[idx_q]} + {vx_q[idx_q][15], vx_q[idx_q]};
    sy = {3'b000, y_q[idx_q]} + {vy_q[idx_q][15], vy_q[idx_q]};

    if (rack_in) begin
      for (int i = 0; i < 10; i++) begin
        x_d[i]      = {rack_x(i), 4'b0000};
        y_d[i]      = {rack_y(i), 4'b0000};
        vx_d[i]     = '0;
        vy_d[i]     = '0;
        pub_x_d[i]  = rack_x(i);
        pub_y_d[i]  = rack_y(i);
        pub_vx_d[i] = '0;
        pub_vy_d[i] = '0;
      end
      down_d     = '0;
      pub_down_d = '0;
      pend_d     = 1'b0;
      busy_d     = 1'b0;
      valid_d    = 1'b1;
      state_d    = S_IDLE;
    end else begin
      // While a pass runs, collision results are parked in the shadow.
      if (state_q != S_IDLE && coll_done_in) begin
        pend_d   = 1'b1;
        sh_hit_d = (pend_q ? sh_hit_q : 10'd0) | pins_hit_in;
        for (int i = 0; i < 10; i++) begin
          if (pins_hit_in[i]) begin
            sh_vx_d[i] = pins_vx_in[i];
            sh_vy_d[i] = pins_vy_in[i];
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (pend_q || coll_done_in) begin
            // Shadow first, then a same-cycle pulse on top of it.
            for (int i = 0; i < 10; i++) begin
              if (!down_q[i]) begin
                if (pend_q && sh_hit_q[i]) begin
                  vx_d[i] = sh_vx_q[i];
                  vy_d[i] = sh_vy_q[i];
                end
                if (coll_done_in && pins_hit_in[i]) begin
                  vx_d[i] = pins_vx_in[i];
                  vy_d[i] = pins_vy_in[i];
                end
              end
              pub_vx_d[i] = vx_d[i];
              pub_vy_d[i] = vy_d[i];
            end
            pend_d = 1'b0;
          end
          if (step_in) begin
            state_d = S_UPDATE;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end

        S_UPDATE: begin
          if (!down_q[idx_q]) begin
            if (sx[16] || sx[15:4] >= LIM_X || sy[16] || sy[15:4] >= LIM_Y) begin
              down_d[idx_q] = 1'b1;
              vx_d[idx_q]   = '0;
              vy_d[idx_q]   = '0;
              x_d[idx_q]    = PARK_X;
              y_d[idx_q]    = PARK_Y;
            end else begin
              x_d[idx_q]  = sx[14:0];
              y_d[idx_q]  = sy[13:0];
              vx_d[idx_q] = decay(vx_q[idx_q]);
              vy_d[idx_q] = decay(vy_q[idx_q]);
            end
          end
          if (idx_q == 4'd9) state_d = S_PUBLISH;
          else idx_d = idx_q + 4'd1;
        end

        S_PUBLISH: begin
          for (int i = 0; i < 10; i++) begin
            pub_x_d[i]  = x_q[i][14:4];
            pub_y_d[i]  = y_q[i][13:4];
            pub_vx_d[i] = vx_q[i];
            pub_vy_d[i] = vy_q[i];
          end
          pub_down_d = down_q;
          busy_d     = 1'b0;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      down_q     <= '0;
      sh_hit_q   <= '0;
      pub_down_q <= '0;
      for (int i = 0; i < 10; i++) begin
        x_q[i]      <= {rack_x(i), 4'b0000};
        y_q[i]      <= {rack_y(i), 4'b0000};
        vx_q[i]     <= '0;
        vy_q[i]     <= '0;
        sh_vx_q[i]  <= '0;
        sh_vy_q[i]  <= '0;
        pub_x_q[i]  <= rack_x(i);
        pub_y_q[i]  <= rack_y(i);
        pub_vx_q[i] <= '0;
        pub_vy_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      down_q     <= down_d;
      sh_hit_q   <= sh_hit_d;
      pub_down_q <= pub_down_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      sh_vx_q    <= sh_vx_d;
      sh_vy_q    <= sh_vy_d;
      pub_x_q    <= pub_x_d;
      pub_y_q    <= pub_y_d;
      pub_vx_q   <= pub_vx_d;
      pub_vy_q   <= pub_vy_d;
    end
  end

  assign pins_x_out    = pub_x_q;
  assign pins_y_out    = pub_y_q;
  assign pins_vx_out   = pub_vx_q;
  assign pins_vy_out   = pub_vy_q;
  assign pins_down_out = pub_down_q;
  assign busy_out      = busy_q;
  assign valid_out     = valid_q;

endmodule

// File: tb/tb_pin_kinematics.sv
// tb/tb_pin_kinematics.sv - directed self-checking bench for pin_kinematics
module tb_pin_kinematics;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             rack_in = 1'b0;
  logic             step_in = 1'b0;
  logic             coll_done_in = 1'b0;
  logic [9:0]       pins_hit_in = '0;
  logic [9:0][15:0] pins_vx_in = '0;
  logic [9:0][15:0] pins_vy_in = '0;
  logic [9:0][10:0] pins_x_out;
  logic [9:0][9:0]  pins_y_out;
  logic [9:0][15:0] pins_vx_out;
  logic [9:0][15:0] pins_vy_out;
  logic [9:0]       pins_down_out;
  logic             busy_out;
  logic             valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  pin_kinematics dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rack_in      (rack_in),
    .step_in      (step_in),
    .coll_done_in (coll_done_in),
    .pins_hit_in  (pins_hit_in),
    .pins_vx_in   (pins_vx_in),
    .pins_vy_in   (pins_vy_in),
    .pins_x_out   (pins_x_out),
    .pins_y_out   (pins_y_out),
    .pins_vx_out  (pins_vx_out),
    .pins_vy_out  (pins_vy_out),
    .pins_down_out(pins_down_out),
    .busy_out     (busy_out),
    .valid_out    (valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic hit(input int p, input int vx, input int vy);
    coll_done_in   = 1'b1;
    pins_hit_in    = 10'(1 << p);
    pins_vx_in[p]  = 16'(vx);
    pins_vy_in[p]  = 16'(vy);
    cycle();
    coll_done_in   = 1'b0;
    pins_hit_in    = '0;
  endtask

  // Pulse step_in, return cycles from the accepting edge to valid_out (-1 on timeout).
  task automatic step_wait(output int lat);
    lat = -1;
    step_in = 1'b1;
    cycle();
    step_in = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (valid_out) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int pulses;

  initial begin
    // Reset state
    cycle();
    cycle();
    rst_in = 1'b0;
    cycle();
    chk("rst_x0", 32'(pins_x_out[0]), 512);
    chk("rst_y9", 32'(pins_y_out[9]), 80);
    chk("rst_x6", 32'(pins_x_out[6]), 440);
    chk("rst_x9", 32'(pins_x_out[9]), 584);
    chk("rst_y1", 32'(pins_y_out[1]), 160);
    chk("rst_vel", 32'(|{pins_vx_out, pins_vy_out}), 0);
    chk("rst_down", 32'(pins_down_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy", 32'(busy_out), 0);

    // Hit pin 0 with vx=+32, then one pass
    hit(0, 32, 0);
    chk("hit0_vx_pub", $signed(pins_vx_out[0]), 32);
    chk("hit0_no_valid", 32'(valid_out), 0);
    step_wait(lat);
    chk("step_latency", lat, 11);
    chk("step_x0", 32'(pins_x_out[0]), 514);
    chk("step_vx0", $signed(pins_vx_out[0]), 28);
    chk("step_y0", 32'(pins_y_out[0]), 200);
    chk("step_x1", 32'(pins_x_out[1]), 488);
    chk("step_busy_end", 32'(busy_out), 0);
    cycle();
    chk("valid_one_cycle", 32'(valid_out), 0);

    // Pin 4 vy=-1: fractional move, then decays to rest
    hit(4, 0, -1);
    step_wait(lat);
    chk("p4_y", 32'(pins_y_out[4]), 119);
    chk("p4_x", 32'(pins_x_out[4]), 512);
    chk("p4_vy_stop", $signed(pins_vy_out[4]), 0);
    step_wait(lat);
    chk("p4_y_rest", 32'(pins_y_out[4]), 119);

    // Pin 9 leaves the lane
    hit(9, 16000, 0);
    step_wait(lat);
    chk("p9_down", 32'(pins_down_out[9]), 1);
    chk("p9_park_x", 32'(pins_x_out[9]), 1024);
    chk("p9_park_y", 32'(pins_y_out[9]), 768);
    chk("p9_vx0", $signed(pins_vx_out[9]), 0);
    chk("p8_up", 32'(pins_down_out[8]), 0);
    hit(9, 100, 5);
    chk("p9_hit_ignored", $signed(pins_vx_out[9]), 0);
    step_wait(lat);
    chk("p9_stays_x", 32'(pins_x_out[9]), 1024);

    // Collision results arriving mid-pass (N+5), plus an ignored step at N+2
    step_in = 1'b1;
    cycle();                      // edge N
    step_in = 1'b0;
    chk("busy_from_N", 32'(busy_out), 1);
    cycle();                      // N+1
    step_in = 1'b1;
    cycle();                      // N+2
    step_in = 1'b0;
    cycle();                      // N+3
    cycle();                      // N+4
    hit(3, 160, 0);               // sampled at N+5
    lat = -1;
    for (int k = 6; k <= 30; k++) begin
      cycle();
      if (valid_out) begin
        lat = k;
        break;
      end
    end
    chk("mid_latency", lat, 11);
    chk("mid_vx3_unaffected", $signed(pins_vx_out[3]), 0);
    chk("mid_x3", 32'(pins_x_out[3]), 464);
    cycle();
    chk("mid_vx3_applied", $signed(pins_vx_out[3]), 160);
    chk("mid_no_second_valid", 32'(valid_out), 0);
    chk("mid_step_not_queued", 32'(busy_out), 0);
    step_wait(lat);
    chk("mid_next_x3", 32'(pins_x_out[3]), 474);
    chk("mid_next_vx3", $signed(pins_vx_out[3]), 140);

    // rack_in at N+4 aborts the pass
    step_in = 1'b1;
    cycle();                      // N
    step_in = 1'b0;
    cycle();                      // N+1
    cycle();                      // N+2
    cycle();                      // N+3
    rack_in = 1'b1;
    cycle();                      // N+4
    rack_in = 1'b0;
    chk("rack_valid", 32'(valid_out), 1);
    chk("rack_busy", 32'(busy_out), 0);
    chk("rack_x3", 32'(pins_x_out[3]), 464);
    chk("rack_vx3", $signed(pins_vx_out[3]), 0);
    chk("rack_x9", 32'(pins_x_out[9]), 584);
    chk("rack_y9", 32'(pins_y_out[9]), 80);
    chk("rack_down", 32'(pins_down_out), 0);
    cycle();
    chk("rack_valid_once", 32'(valid_out), 0);

    // Asynchronous reset mid-pass
    hit(3, 160, 0);
    step_in = 1'b1;
    cycle();
    step_in = 1'b0;
    cycle();
    cycle();
    #2 rst_in = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_out), 0);
    chk("arst_vx3", $signed(pins_vx_out[3]), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      if (valid_out) pulses++;
    end
    chk("arst_no_valid", pulses, 0);
    chk("arst_x3", 32'(pins_x_out[3]), 464);
    chk("arst_x0", 32'(pins_x_out[0]), 512);
    chk("arst_busy_after", 32'(busy_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
